// File: rtl/register_file_writeback.sv
// Write-back stage: captures the destination of each enabled ALU op, commits the
// shared result bus one edge later into a 32x32 register file, with forwarded reads.
module register_file_writeback #(
  parameter  int XLEN      = 32,
  parameter  int REG_COUNT = 32,
  localparam int IDX_W     = $clog2(REG_COUNT)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             writeback_enable,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [XLEN-1:0]  rd_value,
  input  logic [IDX_W-1:0] rs1_index,
  input  logic [IDX_W-1:0] rs2_index,
  output logic [XLEN-1:0]  rs1_value,
  output logic [XLEN-1:0]  rs2_value,
  output logic             write_pending,
  output logic [31:0]      retired_count
);

  typedef enum logic {S_IDLE = 1'b0, S_PENDING = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] pending_rd_q, pending_rd_d;
  logic [XLEN-1:0]  regs_q [REG_COUNT];
  logic [XLEN-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0]      retired_q, retired_d;
  logic             commit;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pending_rd_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_rd_q <= pending_rd_d;
    end
  end

  // Next state: an entry lives exactly one cycle, so the next state depends only on the enable
  always_comb begin
    state_d      = writeback_enable ? S_PENDING : S_IDLE;
    pending_rd_d = writeback_enable ? rd_index : pending_rd_q;
  end

  // Outputs of the FSM: the pending entry commits on this edge
  always_comb begin
    commit        = (state_q == S_PENDING);
    write_pending = (state_q == S_PENDING);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (commit && (pending_rd_q != '0)) begin
      regs_q[pending_rd_q] <= rd_value;
    end
  end

  // Reads see a same-edge commit; x0 never forwards and always reads zero
  always_comb begin
    rs1_d = regs_q[rs1_index];
    rs2_d = regs_q[rs2_index];
    if (commit && (pending_rd_q == rs1_index)) rs1_d = rd_value;
    if (commit && (pending_rd_q == rs2_index)) rs2_d = rd_value;
    if (rs1_index == '0) rs1_d = '0;
    if (rs2_index == '0) rs2_d = '0;
    retired_d = commit ? retired_q + 32'd1 : retired_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      retired_q <= '0;
    end else begin
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      retired_q <= retired_d;
    end
  end

  assign rs1_value     = rs1_q;
  assign rs2_value     = rs2_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_register_file_writeback.sv
// Directed bench for register_file_writeback: a table of per-edge vectors plus
// hand sequences for reset mid-pending and retired_count wrap.
module tb_register_file_writeback;

  logic        clock;
  logic        reset_n;
  logic        writeback_enable;
  logic [4:0]  rd_index;
  logic [31:0] rd_value;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic        write_pending;
  logic [31:0] retired_count;

  int checks;
  int failures;

  register_file_writeback dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .writeback_enable (writeback_enable),
    .rd_index         (rd_index),
    .rd_value         (rd_value),
    .rs1_index        (rs1_index),
    .rs2_index        (rs2_index),
    .rs1_value        (rs1_value),
    .rs2_value        (rs2_value),
    .write_pending    (write_pending),
    .retired_count    (retired_count)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One record = inputs applied before an edge, outputs expected after it
  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    logic        exp_pend;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic we, input logic [4:0] rd, input logic [31:0] val,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic ep, input logic [31:0] ec);
    vec_t v;
    v.we = we; v.rd = rd; v.val = val; v.rs1 = rs1; v.rs2 = rs2;
    v.exp_rs1 = e1; v.exp_rs2 = e2; v.exp_pend = ep; v.exp_cnt = ec;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] val,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    writeback_enable = we;
    rd_index         = rd;
    rd_value         = val;
    rs1_index        = rs1;
    rs2_index        = rs2;
  endtask

  task automatic chk_outputs(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                             input logic ep, input logic [31:0] ec);
    chk({tag, "_rs1"}, rs1_value, e1);
    chk({tag, "_rs2"}, rs2_value, e2);
    chk({tag, "_pend"}, {31'd0, write_pending}, {31'd0, ep});
    chk({tag, "_cnt"}, retired_count, ec);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    reset_n = 1'b0;

    //    we  rd     val           rs1    rs2    exp_rs1       exp_rs2       pend  cnt
    // single write to x3, forwarded on rs1 and rs2 at the commit edge
    add_vec(1, 5'd3,  32'h0,        5'd3,  5'd0,  32'h0,        32'h0,        1, 0);
    add_vec(0, 5'd0,  32'h12345000, 5'd3,  5'd3,  32'h12345000, 32'h12345000, 0, 1);
    add_vec(0, 5'd0,  32'h0,        5'd3,  5'd0,  32'h12345000, 32'h0,        0, 1);
    // back-to-back x1, x2, x3
    add_vec(1, 5'd1,  32'h0,        5'd1,  5'd2,  32'h0,        32'h0,        1, 1);
    add_vec(1, 5'd2,  32'hA,        5'd1,  5'd2,  32'hA,        32'h0,        1, 2);
    add_vec(1, 5'd3,  32'hB,        5'd1,  5'd2,  32'hA,        32'hB,        1, 3);
    add_vec(0, 5'd0,  32'hC,        5'd3,  5'd2,  32'hC,        32'hB,        0, 4);
    add_vec(0, 5'd0,  32'h0,        5'd1,  5'd3,  32'hA,        32'hC,        0, 4);
    // write to x0: discarded, not forwarded, but counted
    add_vec(1, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        1, 4);
    add_vec(0, 5'd0,  32'hFFFFFFFF, 5'd3,  5'd0,  32'hC,        32'h0,        0, 5);
    add_vec(0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        0, 5);
    // overwrite x7 back-to-back with rs1 held on x7
    add_vec(1, 5'd7,  32'h0,        5'd7,  5'd0,  32'h0,        32'h0,        1, 5);
    add_vec(1, 5'd7,  32'h1,        5'd7,  5'd0,  32'h1,        32'h0,        1, 6);
    add_vec(0, 5'd0,  32'h2,        5'd7,  5'd0,  32'h2,        32'h0,        0, 7);
    add_vec(0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h2,        32'h2,        0, 7);
    // x31 with a neighbouring read index that must not forward
    add_vec(1, 5'd31, 32'h0,        5'd31, 5'd30, 32'h0,        32'h0,        1, 7);
    add_vec(0, 5'd0,  32'hDEADBEEF, 5'd30, 5'd31, 32'h0,        32'hDEADBEEF, 0, 8);
    add_vec(0, 5'd0,  32'h0,        5'd31, 5'd1,  32'hDEADBEEF, 32'hA,        0, 8);
    // x16 and x8 exercise the upper index bits
    add_vec(1, 5'd16, 32'h0,        5'd0,  5'd16, 32'h0,        32'h0,        1, 8);
    add_vec(0, 5'd0,  32'h5555AAAA, 5'd16, 5'd0,  32'h5555AAAA, 32'h0,        0, 9);
    add_vec(0, 5'd0,  32'h0,        5'd31, 5'd16, 32'hDEADBEEF, 32'h5555AAAA, 0, 9);
    add_vec(1, 5'd8,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        1, 9);
    add_vec(0, 5'd0,  32'h00000088, 5'd8,  5'd16, 32'h00000088, 32'h5555AAAA, 0, 10);
    add_vec(0, 5'd0,  32'h0,        5'd8,  5'd7,  32'h00000088, 32'h2,        0, 10);

    // Reset state
    #12;
    chk_outputs("reset", 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].we, vq[i].rd, vq[i].val, vq[i].rs1, vq[i].rs2);
      tick();
      chk_outputs($sformatf("row%0d", i), vq[i].exp_rs1, vq[i].exp_rs2,
                  vq[i].exp_pend, vq[i].exp_cnt);
    end

    // Asynchronous reset while x5 is pending: the entry is dropped
    drive(1'b1, 5'd5, 32'h0, 5'd5, 5'd3);
    tick();
    chk("pre_reset_pend", {31'd0, write_pending}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_outputs("async_reset", 32'h0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 5'd0, 32'h00000077, 5'd5, 5'd3);
    tick();
    #2;
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'h00000077, 5'd5, 5'd3);
    tick();
    chk_outputs("after_reset", 32'h0, 32'h0, 1'b0, 32'h0);
    for (int r = 1; r < 32; r++) begin
      drive(1'b0, 5'd0, 32'h0, r[4:0], 5'd0);
      tick();
      chk($sformatf("cleared_x%0d", r), rs1_value, 32'h0);
    end

    // retired_count wraps to zero on the next commit
    drive(1'b1, 5'd4, 32'h0, 5'd4, 5'd0);
    tick();
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    drive(1'b0, 5'd0, 32'h00000044, 5'd4, 5'd4);
    tick();
    chk_outputs("wrap", 32'h00000044, 32'h00000044, 1'b0, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd0);
    tick();
    chk_outputs("post_wrap", 32'h00000044, 32'h0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_writeback.md
# register_file_writeback

Write-back end of the ALU result bus. Each ALU unit (LUI, AUIPC, immediate, register-register) drives its result onto the shared 32-bit `rd_value` bus on the clock edge after its enable and releases it (high impedance) otherwise. This block tracks which destination register each enabled ALU operation targets and commits the bus value into a 32×32 register file one cycle later. It also supplies registered `rs1`/`rs2` read values back to the ALUs, with same-edge write forwarding.

## Interface
Parameters:
- XLEN, 32, data width of registers and the result bus
- REG_COUNT, 32, number of architectural registers; index width is log2(REG_COUNT) = 5

Ports:
- clock  input  1  rising-edge clock shared with all ALU units
- reset_n  input  1  asynchronous, active-low reset
- writeback_enable  input  1  high in the cycle any ALU unit's enable is high; marks an instruction that will produce a result
- rd_index  input  5  destination register of the enabled instruction, valid while writeback_enable = 1
- rd_value  input  XLEN  shared ALU result bus, driven by one ALU the cycle after its enable, Z otherwise
- rs1_index  input  5  read port 1 address
- rs2_index  input  5  read port 2 address
- rs1_value  output  XLEN  registered read data for rs1_index
- rs2_value  output  XLEN  registered read data for rs2_index
- write_pending  output  1  a captured destination is waiting for its bus value
- retired_count  output  32  number of committed write-backs, including writes to x0

## Operation
- Two-stage pipeline: capture, then commit.
- Capture (edge E): if writeback_enable = 1, then pending_rd <= rd_index and pending_valid <= 1; otherwise pending_valid <= 0.
- Commit (edge E+1): if pending_valid = 1, then regs[pending_rd] <= rd_value (unless pending_rd = 0), and retired_count increments by 1 with mod-2^32 wrap.
- x0 is hard-wired to zero. A commit to x0 is discarded but still counted.
- Back-to-back enables: capture and commit happen on the same edge. The old pending entry commits while the new one is captured. Sustained throughput is 1 write per cycle.
- Reads: at every edge, rs1_value <= regs[rs1_index], and likewise for rs2.
  - If a commit to the same nonzero index happens at that edge, the output takes rd_value (forwarding).
  - An index of 0 always yields 0.
- Commit while the bus is Z or X: the value is written as sampled. No checking is done; bus discipline is the ALUs' responsibility.
- write_pending = pending_valid.

## Timing
- Reset (reset_n = 0, asynchronous): all 32 registers, rs1_value, rs2_value, retired_count and pending_rd go to 0, and pending_valid goes to 0. A pending write is discarded, not committed.
- Reset release: the first capture can occur at the first rising edge with reset_n = 1.
- Latency from writeback_enable high to register updated: 2 edges.
- Latency from register updated to the value visible on rsN_value:
  - With forwarding: the same edge as the commit.
  - Without forwarding: the next edge after the commit.
- Latency from rs index change to rsN_value: 1 edge.
- State per entry is IDLE (pending_valid = 0) or PENDING (pending_valid = 1):
  - IDLE → PENDING when writeback_enable = 1.
  - PENDING → PENDING when writeback_enable = 1, committing at the same time.
  - PENDING → IDLE when writeback_enable = 0, committing at the same time.
- No stall input. Once captured, an entry commits unconditionally on the next edge.

## Test plan
- Reset: hold reset_n = 0 mid-pending with rd_index = 5 → registers, outputs and retired_count are 0, and x5 stays 0 after release.
- Single write: enable with rd_index = 3, then drive rd_value = 0x12345000 on the next cycle with rs1_index = 3 → rs1_value = 0x12345000 at the commit edge (forwarded), retired_count = 1, write_pending pulses for 1 cycle.
- Back-to-back: enables on 3 consecutive cycles to x1, x2, x3 with bus values 0xA, 0xB, 0xC each one cycle later → read-back gives x1 = 0xA, x2 = 0xB, x3 = 0xC, retired_count = 3, write_pending is high for 3 cycles.
- x0: write 0xFFFFFFFF to x0 with rs2_index = 0 → rs2_value stays 0 and retired_count increments.
- Overwrite and forward: write x7 = 0x1, then immediately write x7 = 0x2 with rs1_index = 7 held → rs1_value sequence is 0x1, 0x2 with no stale cycle in between.
- Counter wrap: force retired_count to 0xFFFFFFFF and commit one write → retired_count = 0.
